conv2d_layer_ctrl: RTL and testbench
====================================

Name: conv2d_layer_ctrl

Overview:
Sequencer for one binary convolution layer built on the combinational conv2d array (IC input bit-planes, OC output channels, 3x3 kernels, valid padding). It loads input bit-plane rows and per-output-channel weight words over valid/ready streams into local registers that drive the conv array. After a settle window it captures the conv result. It then streams output rows out, channel-major, to the next layer or pooling stage.

Parameters:
IC, 4, input channels (bit-planes)
OC, 8, output channels
IMG_IN_SIZE, 30, input image side N
IMG_OUT_SIZE, IMG_IN_SIZE-2, output image side M
SETTLE_CYCLES, 1, cycles the conv inputs are held stable before capture (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a layer pass; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last output row handshake
in_row_valid  in  1  input row stream valid
in_row_ready  out  1  input row stream ready
in_row_data  in  IMG_IN_SIZE  one row of one bit-plane; bit c is column c
w_valid  in  1  weight stream valid
w_ready  out  1  weight stream ready
w_data  in  IC*9  kernel word for one output channel
conv_img_in  out  IC x (N*N)  to conv array; pixel (r,c) of plane ic at bit r*N+c
conv_weights  out  OC x (IC*9)  to conv array
conv_img_out  in  OC x (M*M)  from conv array
out_row_valid  out  1  output row stream valid
out_row_ready  in  1  output row stream ready
out_row_data  out  IMG_OUT_SIZE  output row; bit c is column c
out_ch  out  clog2(OC)  channel of current output row
out_row  out  clog2(M)  row index of current output row

Behaviour:
- Clocking: single clock clk; rst synchronous, active-high. rst overrides everything, including mid-pass: state returns to IDLE, all counters clear, image and weight registers clear to 0, output capture buffer clears to 0.
- Reset values: busy=0, done=0, in_row_ready=0, w_ready=0, out_row_valid=0, out_row_data=0, out_ch=0, out_row=0.
- Ready and valid flags are decoded from state only: in_row_ready=(state==LOAD_IMG), w_ready=(state==LOAD_W), out_row_valid=(state==STREAM). None of them depends combinationally on the partner's valid or ready.
- IDLE: start=1 moves to LOAD_IMG next cycle. start is ignored in all other states (no queuing).
- LOAD_IMG: each in_row_valid&&in_row_ready handshake writes plane ch_cnt, row row_cnt into bits [row_cnt*N +: N]. row_cnt wraps at N-1 and increments ch_cnt. After the handshake for ch=IC-1, row=N-1, move to LOAD_W. Exactly IC*N handshakes.
- LOAD_W: handshake k (0..OC-1) writes conv_weights[k]. After handshake OC-1, move to SETTLE.
- SETTLE: conv inputs held constant for SETTLE_CYCLES cycles (counter), then CAPTURE.
- CAPTURE: one cycle; latches conv_img_out into the OC x M*M capture buffer; move to STREAM with ch=0, row=0.
- STREAM: out_row_data = capture[ch][row*M +: M]. out_ch, out_row and out_row_data are registered and held stable while valid && !ready. Each handshake advances row; wrap at M-1 advances ch. The handshake for ch=OC-1, row=M-1 moves to IDLE and pulses done for one cycle (the cycle state is IDLE).
- Image and weight registers persist after a pass. The next pass overwrites them fully.
- Zero-stall latency, start seen at cycle 0: LOAD_IMG cycles 1..IC*N; LOAD_W next OC cycles; SETTLE_CYCLES; 1 CAPTURE; OC*M stream cycles; done the cycle after. Defaults: 1+120+8+1+1+224 = done at cycle 355.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package bnn_ctrl_pkg: state enum (IDLE, LOAD_IMG, LOAD_W, SETTLE, CAPTURE, STREAM) and a clog2-width helper constant function.
- One natural sub-module, row_stream_counter: a 2-level (row, channel) wrap counter with advance/clear inputs and a last flag. Instantiated twice, once for load and once for stream.

Test Plan:
- Reset mid-STREAM (after 10 output handshakes) -> next cycle: busy=0, out_row_valid=0, out_ch=0, out_row=0, conv_img_in all zero.
- Load mapping: plane 2, row 5 given data 30'h1, all other rows 0 -> after LOAD_IMG, conv_img_in[2] bit 150 = 1 and every other bit of every plane = 0.
- Weights: stream words k = 36'h0_0000_0001 << k for k=0..7 -> conv_weights[k] matches. Transition to SETTLE happens exactly after 8 handshakes.
- Capture/stream: bench conv model drives conv_img_out[3] = 784'h1 << (28*27+5) -> row with out_ch=3, out_row=27 has out_row_data = 28'h20; all other 223 rows are 0; done fires at cycle 355 with no stalls.
- Backpressure: out_row_ready toggled 0/1 randomly, in_row_valid gaps -> out_row_data, out_ch and out_row stable during stalls; still exactly 224 output handshakes and one done pulse.
- start pulsed during LOAD_W and again during STREAM -> ignored; exactly one pass and a single done pulse.

Source files
------------

// File: rtl/bnn_ctrl_pkg.sv
// bnn_ctrl_pkg: shared definitions for the binary-conv layer sequencer.
//   - FSM state encodings, kept as plain 3-bit constants so that older
//     blocks can keep comparing against raw values
//   - clog2w(): counter/index width helper that never returns zero
package bnn_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD_IMG = 3'd1;
  localparam state_t ST_LOAD_W   = 3'd2;
  localparam state_t ST_SETTLE   = 3'd3;
  localparam state_t ST_CAPTURE  = 3'd4;
  localparam state_t ST_STREAM   = 3'd5;

  // Width of an index over 'value' items; one bit minimum so that a
  // single-item dimension still gets a legal vector.
  function automatic int clog2w(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/conv2d_layer_ctrl_if.sv
// conv2d_layer_ctrl_if: the three valid/ready streams of the layer sequencer.
//   in_row_*  : input bit-plane rows (producer -> sequencer)
//   w_*       : per-output-channel kernel words (producer -> sequencer)
//   out_row_* : captured output rows plus their channel/row tags
//               (sequencer -> next layer)
// modport slave is the sequencer side, modport master the producer/consumer side.
interface conv2d_layer_ctrl_if
  import bnn_ctrl_pkg::*;
#(
  parameter int IC           = 4,
  parameter int OC           = 8,
  parameter int IMG_IN_SIZE  = 30,
  parameter int IMG_OUT_SIZE = IMG_IN_SIZE - 2
);
  localparam int CH_W  = clog2w(OC);
  localparam int ROW_W = clog2w(IMG_OUT_SIZE);

  logic                    in_row_valid;
  logic                    in_row_ready;
  logic [IMG_IN_SIZE-1:0]  in_row_data;

  logic                    w_valid;
  logic                    w_ready;
  logic [IC*9-1:0]         w_data;

  logic                    out_row_valid;
  logic                    out_row_ready;
  logic [IMG_OUT_SIZE-1:0] out_row_data;
  logic [CH_W-1:0]         out_ch;
  logic [ROW_W-1:0]        out_row;

  modport slave (
    input  in_row_valid, in_row_data, w_valid, w_data, out_row_ready,
    output in_row_ready, w_ready, out_row_valid, out_row_data, out_ch, out_row
  );

  modport master (
    output in_row_valid, in_row_data, w_valid, w_data, out_row_ready,
    input  in_row_ready, w_ready, out_row_valid, out_row_data, out_ch, out_row
  );

endinterface

// File: rtl/conv2d_layer_ctrl_row_stream_counter.sv
// row_stream_counter: two-level (row inner, channel outer) wrap counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : return to (0,0) next cycle; wins over advance
//   advance  : step one row, wrapping ROWS-1 -> 0 and bumping the channel
//   row, ch  : current position (registered)
//   last     : position is (CHS-1, ROWS-1)
module row_stream_counter
  import bnn_ctrl_pkg::*;
#(
  parameter int ROWS  = 30,
  parameter int CHS   = 4,
  parameter int ROW_W = clog2w(ROWS),
  parameter int CH_W  = clog2w(CHS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [CH_W-1:0]  ch,
  output logic             last
);

  logic [ROW_W-1:0] row_r;
  logic [ROW_W-1:0] row_nxt_s;
  logic [CH_W-1:0]  ch_r;
  logic [CH_W-1:0]  ch_nxt_s;
  logic             row_wrap_s;
  logic             ch_wrap_s;

  assign row_wrap_s = (row_r == ROW_W'(ROWS - 1));
  assign ch_wrap_s  = (ch_r == CH_W'(CHS - 1));
  assign last       = row_wrap_s && ch_wrap_s;
  assign row        = row_r;
  assign ch         = ch_r;

  // Next position: clear, advance with two-level wrap, or hold.
  always_comb begin
    row_nxt_s = row_r;
    ch_nxt_s  = ch_r;
    if (clear) begin
      row_nxt_s = {ROW_W{1'b0}};
      ch_nxt_s  = {CH_W{1'b0}};
    end else if (advance) begin
      if (row_wrap_s) begin
        row_nxt_s = {ROW_W{1'b0}};
        if (ch_wrap_s) begin
          ch_nxt_s = {CH_W{1'b0}};
        end else begin
          ch_nxt_s = ch_r + CH_W'(1'b1);
        end
      end else begin
        row_nxt_s = row_r + ROW_W'(1'b1);
        ch_nxt_s  = ch_r;
      end
    end else begin
      row_nxt_s = row_r;
      ch_nxt_s  = ch_r;
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r <= {ROW_W{1'b0}};
      ch_r  <= {CH_W{1'b0}};
    end else begin
      row_r <= row_nxt_s;
      ch_r  <= ch_nxt_s;
    end
  end

endmodule

// File: rtl/conv2d_layer_ctrl.sv
// conv2d_layer_ctrl: sequencer for one binary 3x3 valid-padding conv layer.
//   clk, rst       : clock, synchronous active-high reset (overrides all)
//   start          : begin a pass; only honoured in IDLE
//   busy, done     : busy outside IDLE; done pulses once after the last row
//   bus (slave)    : input-row, weight and output-row valid/ready streams
//   conv_img_in    : IC bit-planes, pixel (r,c) at bit r*N+c, to the conv array
//   conv_weights   : OC kernel words, to the conv array
//   conv_img_out   : OC result planes from the conv array
// Flow: LOAD_IMG (IC*N rows) -> LOAD_W (OC words) -> SETTLE -> CAPTURE ->
// STREAM (OC*M rows, channel-major) -> IDLE.
module conv2d_layer_ctrl
  import bnn_ctrl_pkg::*;
#(
  parameter int IC            = 4,
  parameter int OC            = 8,
  parameter int IMG_IN_SIZE   = 30,
  parameter int IMG_OUT_SIZE  = IMG_IN_SIZE - 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  conv2d_layer_ctrl_if.slave                            bus,
  output logic [IC-1:0][IMG_IN_SIZE*IMG_IN_SIZE-1:0]    conv_img_in,
  output logic [OC-1:0][IC*9-1:0]                       conv_weights,
  input  logic [OC-1:0][IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]  conv_img_out
);

  localparam int N        = IMG_IN_SIZE;
  localparam int M        = IMG_OUT_SIZE;
  localparam int LD_CH_W  = clog2w(IC);
  localparam int LD_ROW_W = clog2w(N);
  localparam int WK_W     = clog2w(OC);

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic                        busy_r;
  logic                        done_r;
  logic                        in_ready_r;
  logic                        w_ready_r;
  logic                        out_valid_r;
  logic [WK_W-1:0]             w_cnt_r;
  logic [3:0]                  settle_cnt_r;
  logic [IC-1:0][N*N-1:0]      img_r;
  logic [OC-1:0][IC*9-1:0]     w_r;
  // Channel-major flattening puts row (ch,row) at bit ch*M*M + row*M, so
  // streaming order is simply successive M-bit chunks from the bottom.
  logic [OC*M*M-1:0]           cap_r;

  logic                        in_hs_s;
  logic                        w_hs_s;
  logic                        out_hs_s;
  logic                        w_last_s;
  logic                        settle_end_s;
  logic [LD_ROW_W-1:0]         ld_row_s;
  logic [LD_CH_W-1:0]          ld_ch_s;
  logic                        ld_last_s;
  logic                        st_last_s;

  assign in_hs_s      = bus.in_row_valid && in_ready_r;
  assign w_hs_s       = bus.w_valid && w_ready_r;
  assign out_hs_s     = out_valid_r && bus.out_row_ready;
  assign w_last_s     = (w_cnt_r == WK_W'(OC - 1));
  assign settle_end_s = (settle_cnt_r == 4'(SETTLE_CYCLES - 1));

  assign busy              = busy_r;
  assign done              = done_r;
  assign bus.in_row_ready  = in_ready_r;
  assign bus.w_ready       = w_ready_r;
  assign bus.out_row_valid = out_valid_r;
  assign bus.out_row_data  = cap_r[M-1:0];
  assign conv_img_in       = img_r;
  assign conv_weights      = w_r;

  row_stream_counter #(.ROWS(N), .CHS(IC)) u_load_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_r == ST_IDLE),
    .advance (in_hs_s),
    .row     (ld_row_s),
    .ch      (ld_ch_s),
    .last    (ld_last_s)
  );

  row_stream_counter #(.ROWS(M), .CHS(OC)) u_stream_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_r == ST_CAPTURE),
    .advance (out_hs_s),
    .row     (bus.out_row),
    .ch      (bus.out_ch),
    .last    (st_last_s)
  );

  // Next-state decode for the pass sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_LOAD_IMG;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LOAD_IMG: begin
        if (in_hs_s && ld_last_s) state_nxt_s = ST_LOAD_W;
        else                      state_nxt_s = ST_LOAD_IMG;
      end
      ST_LOAD_W: begin
        if (w_hs_s && w_last_s) state_nxt_s = ST_SETTLE;
        else                    state_nxt_s = ST_LOAD_W;
      end
      ST_SETTLE: begin
        if (settle_end_s) state_nxt_s = ST_CAPTURE;
        else              state_nxt_s = ST_SETTLE;
      end
      ST_CAPTURE: state_nxt_s = ST_STREAM;
      ST_STREAM: begin
        if (out_hs_s && st_last_s) state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_STREAM;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State plus flags; flags are decoded from the next state so each one
  // is a flop that always equals a decode of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      w_ready_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= out_hs_s && st_last_s;
      in_ready_r  <= (state_nxt_s == ST_LOAD_IMG);
      w_ready_r   <= (state_nxt_s == ST_LOAD_W);
      out_valid_r <= (state_nxt_s == ST_STREAM);
    end
  end

  // Weight-word index and settle-window counters.
  always_ff @(posedge clk) begin
    if (rst || (state_r == ST_IDLE)) begin
      w_cnt_r <= {WK_W{1'b0}};
    end else if (w_hs_s) begin
      w_cnt_r <= w_last_s ? {WK_W{1'b0}} : (w_cnt_r + WK_W'(1'b1));
    end
    if (rst || (state_r != ST_SETTLE)) begin
      settle_cnt_r <= 4'd0;
    end else begin
      settle_cnt_r <= settle_cnt_r + 4'd1;
    end
  end

  // Image planes, kernel words and the output capture/stream buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      img_r <= '0;
      w_r   <= '0;
      cap_r <= '0;
    end else begin
      if (in_hs_s) img_r[ld_ch_s][ld_row_s*N +: N] <= bus.in_row_data;
      if (w_hs_s)  w_r[w_cnt_r] <= bus.w_data;
      if (state_r == ST_CAPTURE) begin
        cap_r <= conv_img_out;
      end else if (out_hs_s) begin
        cap_r <= cap_r >> M;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_layer_ctrl.sv
module tb_conv2d_layer_ctrl;
  import bnn_ctrl_pkg::*;

  localparam int IC = 4;
  localparam int OC = 8;
  localparam int N  = 30;
  localparam int M  = 28;
  localparam int ROWS_OUT = OC * M;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic [IC-1:0][N*N-1:0]  conv_img_in;
  logic [OC-1:0][IC*9-1:0] conv_weights;
  logic [OC-1:0][M*M-1:0]  conv_img_out;

  conv2d_layer_ctrl_if #(.IC(IC), .OC(OC), .IMG_IN_SIZE(N), .IMG_OUT_SIZE(M)) bus ();

  conv2d_layer_ctrl #(.IC(IC), .OC(OC), .IMG_IN_SIZE(N), .IMG_OUT_SIZE(M), .SETTLE_CYCLES(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .bus          (bus),
    .conv_img_in  (conv_img_in),
    .conv_weights (conv_weights),
    .conv_img_out (conv_img_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_timeout = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned hs_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  logic [M-1:0] got_data [0:2047];
  logic [2:0]   got_ch   [0:2047];
  logic [4:0]   got_row  [0:2047];

  // cycle counter and output-handshake recorder
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.out_row_valid && bus.out_row_ready) begin
      if (hs_cnt < 2048) begin
        got_data[hs_cnt] <= bus.out_row_data;
        got_ch[hs_cnt]   <= bus.out_ch;
        got_row[hs_cnt]  <= bus.out_row;
      end
      hs_cnt <= hs_cnt + 1;
    end
  end

  // done pulse recorder
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc - start_cyc;
    end
  end

  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_images(input bit gaps);
    for (int ch = 0; ch < IC; ch++) begin
      for (int r = 0; r < N; r++) begin
        if (gaps && ($urandom_range(0, 2) == 0)) begin
          bus.in_row_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.in_row_valid = 1'b1;
        bus.in_row_data  = (ch == 2 && r == 5) ? 30'h1 : 30'h0;
        for (int t = 0; t < 400 && bus.in_row_ready !== 1'b1; t++) @(negedge clk);
        if (bus.in_row_ready !== 1'b1) n_timeout++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    bus.in_row_valid = 1'b0;
  endtask

  task automatic load_weights(input bit gaps);
    logic [35:0] one36;
    one36 = 36'd1;
    for (int k = 0; k < OC; k++) begin
      if (gaps && ($urandom_range(0, 1) == 0)) begin
        bus.w_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.w_valid = 1'b1;
      bus.w_data  = one36 << k;
      for (int t = 0; t < 400 && bus.w_ready !== 1'b1; t++) @(negedge clk);
      if (bus.w_ready !== 1'b1) n_timeout++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.w_valid = 1'b0;
  endtask

  // drives out_row_ready until done (or stop_after handshakes); tracks stalls
  task automatic drain(input bit rnd, input int stop_after, output int stalls, output int unstable);
    int unsigned base_hs;
    bit pstall;
    bit finished;
    logic [M-1:0] pd;
    logic [2:0] pc;
    logic [4:0] pr;
    base_hs = hs_cnt;
    pstall = 1'b0;
    finished = 1'b0;
    stalls = 0;
    unstable = 0;
    pd = '0; pc = '0; pr = '0;
    for (int t = 0; t < 4000 && !finished; t++) begin
      @(negedge clk);
      if (pstall && (bus.out_row_valid !== 1'b1 || bus.out_row_data !== pd ||
                     bus.out_ch !== pc || bus.out_row !== pr)) unstable++;
      if (done === 1'b1) finished = 1'b1;
      else if (stop_after > 0 && int'(hs_cnt - base_hs) >= stop_after) finished = 1'b1;
      else begin
        bus.out_row_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pstall = bus.out_row_valid && !bus.out_row_ready;
        if (pstall) stalls++;
        pd = bus.out_row_data; pc = bus.out_ch; pr = bus.out_row;
      end
    end
    if (!finished) n_timeout++;
  endtask

  task automatic test_reset();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (bus.in_row_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_row_ready); end
    n_cmp++; if (bus.w_ready !== 1'b0) begin n_err++; $display("FAIL reset_w_ready: got %b want 0", bus.w_ready); end
    n_cmp++; if (bus.out_row_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_row_valid); end
    n_cmp++; if (bus.out_row_data !== 28'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", bus.out_row_data); end
    n_cmp++; if (bus.out_ch !== 3'd0) begin n_err++; $display("FAIL reset_out_ch: got %0d want 0", bus.out_ch); end
    n_cmp++; if (bus.out_row !== 5'd0) begin n_err++; $display("FAIL reset_out_row: got %0d want 0", bus.out_row); end
    n_cmp++; if (conv_img_in !== '0) begin n_err++; $display("FAIL reset_img: got %0d ones want 0", $countones(conv_img_in)); end
    n_cmp++; if (conv_weights !== '0) begin n_err++; $display("FAIL reset_weights: got %h want 0", conv_weights); end
  endtask

  task automatic test_load_and_stream();
    int unsigned hs0, dn0;
    int tmo0, stalls, unst, exp_ch, exp_row;
    logic [IC-1:0][N*N-1:0] exp_img;
    logic [35:0] one36, exp_w;
    logic [M-1:0] exp_d;
    hs0 = hs_cnt; dn0 = done_cnt; tmo0 = n_timeout;
    exp_img = '0;
    exp_img[2][150] = 1'b1;
    one36 = 36'd1;
    start_pass();
    load_images(1'b0);
    n_cmp++; if (conv_img_in !== exp_img) begin n_err++; $display("FAIL load_map: got %0d ones, bit150 of plane2=%b want 1 one at plane2 bit150", $countones(conv_img_in), conv_img_in[2][150]); end
    n_cmp++; if (bus.w_ready !== 1'b1) begin n_err++; $display("FAIL load_to_w: w_ready got %b want 1", bus.w_ready); end
    load_weights(1'b0);
    n_cmp++; if (bus.w_ready !== 1'b0) begin n_err++; $display("FAIL w_to_settle: w_ready got %b want 0", bus.w_ready); end
    n_cmp++; if (busy !== 1'b1 || bus.in_row_ready !== 1'b0 || bus.out_row_valid !== 1'b0) begin n_err++; $display("FAIL settle_flags: busy/in_rdy/out_vld got %b%b%b want 100", busy, bus.in_row_ready, bus.out_row_valid); end
    for (int k = 0; k < OC; k++) begin
      exp_w = one36 << k;
      n_cmp++; if (conv_weights[k] !== exp_w) begin n_err++; $display("FAIL weight_%0d: got %h want %h", k, conv_weights[k], exp_w); end
    end
    drain(1'b0, 0, stalls, unst);
    @(negedge clk);
    n_cmp++; if (done_cyc != 355) begin n_err++; $display("FAIL done_cycle: got %0d want 355", done_cyc); end
    n_cmp++; if (done_cnt - dn0 != 1) begin n_err++; $display("FAIL done_count: got %0d want 1", done_cnt - dn0); end
    n_cmp++; if (hs_cnt - hs0 != ROWS_OUT) begin n_err++; $display("FAIL out_hs_count: got %0d want %0d", hs_cnt - hs0, ROWS_OUT); end
    for (int k = 0; k < ROWS_OUT; k++) begin
      exp_ch = k / M; exp_row = k % M;
      exp_d = (exp_ch == 3 && exp_row == 27) ? 28'h20 : 28'h0;
      n_cmp++;
      if (got_ch[hs0+k] !== 3'(exp_ch) || got_row[hs0+k] !== 5'(exp_row) || got_data[hs0+k] !== exp_d) begin
        n_err++;
        $display("FAIL stream_row_%0d: got ch%0d row%0d data %h want ch%0d row%0d data %h", k, got_ch[hs0+k], got_row[hs0+k], got_data[hs0+k], exp_ch, exp_row, exp_d);
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_pass: busy got %b want 0", busy); end
    n_cmp++; if (n_timeout != tmo0) begin n_err++; $display("FAIL pass_timeout: got %0d expired waits want 0", n_timeout - tmo0); end
  endtask

  task automatic test_backpressure();
    int unsigned hs0, dn0;
    int tmo0, stalls, unst, bad_rows, exp_ch, exp_row;
    logic [IC-1:0][N*N-1:0] exp_img;
    logic [M-1:0] exp_d;
    hs0 = hs_cnt; dn0 = done_cnt; tmo0 = n_timeout;
    exp_img = '0;
    exp_img[2][150] = 1'b1;
    bus.out_row_ready = 1'b0;
    start_pass();
    load_images(1'b1);
    n_cmp++; if (conv_img_in !== exp_img) begin n_err++; $display("FAIL bp_load_map: got %0d ones want 1", $countones(conv_img_in)); end
    load_weights(1'b1);
    drain(1'b1, 0, stalls, unst);
    @(negedge clk);
    n_cmp++; if (unst != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", unst); end
    n_cmp++; if (stalls == 0) begin n_err++; $display("FAIL bp_stalls_seen: got %0d stall cycles want >0", stalls); end
    n_cmp++; if (hs_cnt - hs0 != ROWS_OUT) begin n_err++; $display("FAIL bp_hs_count: got %0d want %0d", hs_cnt - hs0, ROWS_OUT); end
    n_cmp++; if (done_cnt - dn0 != 1) begin n_err++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - dn0); end
    bad_rows = 0;
    for (int k = 0; k < ROWS_OUT; k++) begin
      exp_ch = k / M; exp_row = k % M;
      exp_d = (exp_ch == 3 && exp_row == 27) ? 28'h20 : 28'h0;
      if (got_ch[hs0+k] !== 3'(exp_ch) || got_row[hs0+k] !== 5'(exp_row) || got_data[hs0+k] !== exp_d) bad_rows++;
    end
    n_cmp++; if (bad_rows != 0) begin n_err++; $display("FAIL bp_rows: got %0d wrong rows want 0", bad_rows); end
    n_cmp++; if (n_timeout != tmo0) begin n_err++; $display("FAIL bp_timeout: got %0d expired waits want 0", n_timeout - tmo0); end
  endtask

  task automatic test_start_ignored();
    int unsigned hs0, dn0;
    int tmo0, stalls, unst;
    hs0 = hs_cnt; dn0 = done_cnt; tmo0 = n_timeout;
    bus.out_row_ready = 1'b1;
    start_pass();
    load_images(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_weights(1'b0);
    drain(1'b0, 100, stalls, unst);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(1'b0, 0, stalls, unst);
    repeat (20) @(negedge clk);
    n_cmp++; if (done_cnt - dn0 != 1) begin n_err++; $display("FAIL start_ign_done: got %0d want 1", done_cnt - dn0); end
    n_cmp++; if (hs_cnt - hs0 != ROWS_OUT) begin n_err++; $display("FAIL start_ign_hs: got %0d want %0d", hs_cnt - hs0, ROWS_OUT); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_ign_idle: busy got %b want 0", busy); end
    n_cmp++; if (n_timeout != tmo0) begin n_err++; $display("FAIL start_ign_timeout: got %0d expired waits want 0", n_timeout - tmo0); end
  endtask

  task automatic test_reset_mid_stream();
    int tmo0, stalls, unst;
    tmo0 = n_timeout;
    bus.out_row_ready = 1'b1;
    start_pass();
    load_images(1'b0);
    load_weights(1'b0);
    drain(1'b0, 10, stalls, unst);
    bus.out_row_ready = 1'b0;
    n_cmp++; if (bus.out_row !== 5'd10 || bus.out_ch !== 3'd0) begin n_err++; $display("FAIL mid_position: got ch%0d row%0d want ch0 row10", bus.out_ch, bus.out_row); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (bus.out_row_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_row_valid); end
    n_cmp++; if (bus.out_ch !== 3'd0 || bus.out_row !== 5'd0) begin n_err++; $display("FAIL mid_rst_pos: got ch%0d row%0d want ch0 row0", bus.out_ch, bus.out_row); end
    n_cmp++; if (conv_img_in !== '0) begin n_err++; $display("FAIL mid_rst_img: got %0d ones want 0", $countones(conv_img_in)); end
    n_cmp++; if (conv_weights !== '0) begin n_err++; $display("FAIL mid_rst_weights: got %h want 0", conv_weights); end
    n_cmp++; if (n_timeout != tmo0) begin n_err++; $display("FAIL mid_rst_timeout: got %0d expired waits want 0", n_timeout - tmo0); end
  endtask

  initial begin
    logic [M*M-1:0] one784;
    rst = 1'b1;
    start = 1'b0;
    bus.in_row_valid = 1'b0;
    bus.in_row_data = '0;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.out_row_ready = 1'b1;
    one784 = '0;
    one784[0] = 1'b1;
    conv_img_out = '0;
    conv_img_out[3] = one784 << (28*27 + 5);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_load_and_stream();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
